arith_unit: RTL and testbench

- Registered integer arithmetic unit for the verification sandbox.
- Computes, on the same operand pair, an unsigned ripple-carry sum, a carry-lookahead sum or an unsigned product, and registers the selected result.
- It is the single DUT the class-based environment drives; the environment chooses the operation per transaction through op_sel.

---
 rtl/arith_pkg.sv | 13 +
 rtl/cla_group4.sv | 32 +++
 rtl/arith_unit.sv | 153 +++++++++++++++
 tb/tb_arith_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types and constants for the arith_unit datapath.
package arith_pkg;

   typedef enum logic [1:0] {
      OP_ADD_RCA = 2'd0,
      OP_ADD_CLA = 2'd1,
      OP_MUL     = 2'd2,
      OP_RSVD    = 2'd3
   } op_e;

   localparam int CLA_GROUP = 4;

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead slice: two-level carries, group generate/propagate.
module cla_group4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       g,
   output logic       p,
   output logic       cout
);

   logic [3:0] gen, prop;
   logic [3:0] c;

   assign gen  = a & b;
   assign prop = a ^ b;

   // Every internal carry is a flat sum of products of gen/prop/cin.
   assign c[0] = cin;
   assign c[1] = gen[0] | (prop[0] & cin);
   assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
   assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
               | (prop[2] & prop[1] & prop[0] & cin);

   assign g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
            | (prop[3] & prop[2] & prop[1] & gen[0]);
   assign p = &prop;

   assign sum  = prop ^ c;
   assign cout = g | (p & cin);

endmodule

// File: rtl/arith_unit.sv
// Registered unsigned arithmetic unit: RCA add, CLA add, shift-and-add multiply.
// Define ARITH_XCHECK_EN to build the RCA-vs-CLA cross-check driving xcheck_err.
module arith_unit
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [1:0]           op_sel,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   output logic [2*WIDTH-1:0]   result,
   output logic                 carry_out,
   output logic                 op_err,
   output logic                 xcheck_err
);

   localparam int NG = WIDTH / CLA_GROUP;

   op_e op;
   assign op = op_e'(op_sel);

   // Ripple-carry adder: one full adder per bit.
   logic [WIDTH-1:0] rca_sum;
   logic [WIDTH:0]   rca_c;

   always_comb begin
      rca_c   = '0;
      rca_sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rca_sum[i]  = a[i] ^ b[i] ^ rca_c[i];
         rca_c[i+1]  = (a[i] & b[i]) | (rca_c[i] & (a[i] ^ b[i]));
      end
   end

   // Carry-lookahead adder: group carries come from each slice's G/P, so the
   // chain never loops back through a slice's own cin.
   logic [WIDTH-1:0] cla_sum;
   logic [NG-1:0]    grp_g, grp_p, grp_cout, grp_cin;
   logic             cla_co;
   logic             cout_unused;

   for (genvar gi = 0; gi < NG; gi++) begin : g_cla
      cla_group4 u_grp (
         .a    (a[gi*CLA_GROUP +: CLA_GROUP]),
         .b    (b[gi*CLA_GROUP +: CLA_GROUP]),
         .cin  (grp_cin[gi]),
         .sum  (cla_sum[gi*CLA_GROUP +: CLA_GROUP]),
         .g    (grp_g[gi]),
         .p    (grp_p[gi]),
         .cout (grp_cout[gi])
      );
   end

   always_comb begin
      grp_cin    = '0;
      grp_cin[0] = 1'b0;
      for (int gi = 0; gi < NG - 1; gi++) begin
         grp_cin[gi+1] = grp_g[gi] | (grp_p[gi] & grp_cin[gi]);
      end
   end

   assign cla_co      = grp_cout[NG-1];
   assign cout_unused = ^grp_cout;

   // Shift-and-add multiplier over the bits of b.
   logic [2*WIDTH-1:0] mul_prod;

   always_comb begin
      mul_prod = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (b[i]) mul_prod = mul_prod + ({{WIDTH{1'b0}}, a} << i);
      end
   end

   logic               out_valid_d, out_valid_q;
   logic [2*WIDTH-1:0] result_d, result_q;
   logic               carry_d, carry_q;
   logic               op_err_d, op_err_q;

   always_comb begin
      out_valid_d = in_valid;
      result_d    = result_q;
      carry_d     = carry_q;
      op_err_d    = op_err_q;
      if (in_valid) begin
         case (op)
            OP_ADD_RCA: begin
               result_d = {{WIDTH{1'b0}}, rca_sum};
               carry_d  = rca_c[WIDTH];
               op_err_d = 1'b0;
            end
            OP_ADD_CLA: begin
               result_d = {{WIDTH{1'b0}}, cla_sum};
               carry_d  = cla_co;
               op_err_d = 1'b0;
            end
            OP_MUL: begin
               result_d = mul_prod;
               carry_d  = 1'b0;
               op_err_d = 1'b0;
            end
            default: begin
               result_d = '0;
               carry_d  = 1'b0;
               op_err_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         op_err_q    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         op_err_q    <= op_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carry_out = carry_q;
   assign op_err    = op_err_q;

`ifdef ARITH_XCHECK_EN
   // Diagnostic only: both adders are compared on every accepted operand pair.
   logic xcheck_d, xcheck_q;

   always_comb begin
      xcheck_d = xcheck_q;
      if (in_valid) xcheck_d = (rca_sum != cla_sum) || (rca_c[WIDTH] != cla_co);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) xcheck_q <= 1'b0;
      else        xcheck_q <= xcheck_d;
   end

   assign xcheck_err = xcheck_q;
`else
   assign xcheck_err = 1'b0;
`endif

endmodule

// File: tb/tb_arith_unit.sv
// Scoreboard bench for arith_unit (WIDTH=8): directed plan vectors, random stream, mid-stream reset.
module tb_arith_unit;
   import arith_pkg::*;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           in_valid = 1'b0;
   logic [1:0]     op_sel = '0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           out_valid;
   logic [2*W-1:0] result;
   logic           carry_out;
   logic           op_err;
   logic           xcheck_err;

   typedef struct packed {
      logic [2*W-1:0] res;
      logic           co;
      logic           err;
   } exp_t;

   exp_t           sb[$];
   exp_t           e;
   int             n_vec = 0;
   int             n_err = 0;
   logic           exp_ov = 1'b0;
   logic [2*W-1:0] last_res = '0;
   logic           last_co = 1'b0;
   logic           last_err = 1'b0;

   always #5 clk = ~clk;

   arith_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .op_sel     (op_sel),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .result     (result),
      .carry_out  (carry_out),
      .op_err     (op_err),
      .xcheck_err (xcheck_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0]     s;
      logic [2*W-1:0] xx, yy;
      exp_t           r;
      r  = '0;
      xx = {{W{1'b0}}, x};
      yy = {{W{1'b0}}, y};
      case (op)
         2'd0, 2'd1: begin
            s     = {1'b0, x} + {1'b0, y};
            r.res = {{W{1'b0}}, s[W-1:0]};
            r.co  = s[W];
         end
         2'd2:    r.res = xx * yy;
         default: r.err = 1'b1;
      endcase
      return r;
   endfunction

   task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      @(posedge clk);
      #1;
      in_valid = v;
      op_sel   = op;
      a        = x;
      b        = y;
      if (v) sb.push_back(model(op, x, y));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ov"},  32'(out_valid),  0);
      check({tag, "_res"}, 32'(result),     0);
      check({tag, "_co"},  32'(carry_out),  0);
      check({tag, "_err"}, 32'(op_err),     0);
      check({tag, "_xc"},  32'(xcheck_err), 0);
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) exp_ov <= 1'b0;
      else        exp_ov <= in_valid;
   end

   // Pops one expectation per valid output; idle cycles must hold the last result.
   always @(negedge clk) begin
      if (!reset) begin
         check_zero("rst_hold");
         sb.delete();
         last_res = '0;
         last_co  = 1'b0;
         last_err = 1'b0;
      end else begin
         check("out_valid", 32'(out_valid), 32'(exp_ov));
         if (exp_ov) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'(sb.size()), 1);
            end else begin
               e = sb.pop_front();
               check("result",  32'(result),     32'(e.res));
               check("carry",   32'(carry_out),  32'(e.co));
               check("op_err",  32'(op_err),     32'(e.err));
               check("xcheck",  32'(xcheck_err), 0);
               last_res = e.res;
               last_co  = e.co;
               last_err = e.err;
            end
         end else begin
            check("hold_res", 32'(result),    32'(last_res));
            check("hold_co",  32'(carry_out), 32'(last_co));
            check("hold_err", 32'(op_err),    32'(last_err));
         end
      end
   end

   initial begin
      #2;
      check_zero("por");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      drive(1'b1, 2'd0, 8'd100, 8'd55);
      drive(1'b1, 2'd1, 8'hFF, 8'h01);
      drive(1'b1, 2'd0, 8'hFF, 8'h01);
      drive(1'b1, 2'd2, 8'hFF, 8'hFF);
      drive(1'b1, 2'd2, 8'h00, 8'hAB);
      drive(1'b1, 2'd3, 8'd5,  8'd6);
      drive(1'b1, 2'd0, 8'd7,  8'd9);
      drive(1'b0, 2'd0, 8'd0,  8'd0);
      drive(1'b1, 2'd0, 8'd1,  8'd1);
      drive(1'b1, 2'd1, 8'd2,  8'd2);
      drive(1'b1, 2'd2, 8'd3,  8'd3);
      drive(1'b0, 2'd0, 8'd0,  8'd0);
      drive(1'b1, 2'd1, 8'h80, 8'h80);
      drive(1'b1, 2'd1, 8'h7F, 8'h80);

      for (int i = 0; i < 80; i++) begin
         drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
               W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      end

      // Reset between edges with one result registered and one still at the inputs.
      drive(1'b1, 2'd2, 8'd12,  8'd13);
      drive(1'b1, 2'd0, 8'd200, 8'd100);
      #2;
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      check_zero("mid_rst");
      @(negedge clk);
      #1;
      reset = 1'b1;
      repeat (4) drive(1'b0, 2'd0, 8'd0, 8'd0);

      drive(1'b1, 2'd1, 8'hF0, 8'h10);
      drive(1'b1, 2'd2, 8'h10, 8'h10);
      drive(1'b0, 2'd0, 8'd0, 8'd0);

      for (int i = 0; i < 10; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
         #1;
      end
      check("drain", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
